alert_sequencer: RTL and testbench
==================================

# alert_sequencer

Frame-synchronous controller that schedules when the full-screen alert overlay is shown and which alert is shown. It takes alert requests from up to `NUM_REQ` game-logic requesters and grants them round-robin. Each granted alert is displayed for a fixed number of frames with a blink cadence, followed by a mandatory gap. It drives the overlay select and alert index consumed by the video mux and the alert mapper/palette stage. All state changes happen at the frame origin, so an alert never starts or stops mid-frame.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `SHOW_FRAMES`, 120: frames an alert is displayed (≥1).
- `BLINK_FRAMES`, 15: frames per blink half-period (≥1).
- `GAP_FRAMES`, 30: blank frames enforced between consecutive alerts (≥0).

Ports:
- `vga_clk`  in  1: pixel clock; the only clock.
- `Reset`  in  1: synchronous, active-high.
- `DrawX`, `DrawY`  in  10 each: current scan position.
- `alert_req`  in  NUM_REQ: per-requester request pulses or levels; sampled every cycle.
- `dismiss`  in  1: early-terminate the current alert.
- `alert_ack`  out  NUM_REQ: one-cycle one-hot pulse when that requester is granted.
- `alert_id`  out  $clog2(NUM_REQ): index of the granted alert; selects the ROM image/palette.
- `alert_on`  out  1: overlay select; high means alert pixels replace the game pixels.
- `busy`  out  1: high in every state except IDLE.

## Operation
- Frame tick: `ftick` is a one-cycle pulse on the first cycle where DrawX==0 and DrawY==0. It is the registered edge of that condition, so it cannot re-fire while the position is held.
- Pending register, `pend[NUM_REQ]`: set by `alert_req[i]`, cleared when requester i is granted. If set and clear hit the same cycle, set wins and the request stays pending.
- Arbitration: round-robin starting from `last_id+1` mod NUM_REQ. After reset, `last_id` = NUM_REQ-1, so requester 0 has top priority.
- States:
  - IDLE: if any `pend` is set, grant in this cycle. Pulse `alert_ack[g]`, latch `alert_id`=g, clear `pend[g]`, go to ARM.
  - ARM: wait for `ftick`, then go to SHOW. Load `frame_cnt`=SHOW_FRAMES-1, `blink_cnt`=BLINK_FRAMES-1, `phase`=1.
  - SHOW: on each `ftick`:
    - if `frame_cnt`==0 or `dismiss_pend`, go to GAP with `gap_cnt`=GAP_FRAMES-1, or straight to IDLE if GAP_FRAMES==0;
    - otherwise decrement `frame_cnt`;
    - on the same tick, `blink_cnt` decrements, and on 0 it reloads and toggles `phase`.
  - GAP: on each `ftick`, if `gap_cnt`==0 go to IDLE, else decrement.
- Dismiss: `dismiss` sets a sticky `dismiss_pend` flag only while in SHOW. The flag takes effect at the next `ftick` and clears on leaving SHOW. Dismiss in any other state is ignored.
- `alert_on` = (state==SHOW) && `phase`, registered.
- `alert_id` holds its value through ARM, SHOW and GAP. It changes only on a grant.
- Requests arriving during ARM, SHOW or GAP are queued in `pend` and never dropped. A repeat request from the same requester before it is granted collapses into one.

## Timing
- Reset values: state=IDLE, `pend`=0, `alert_ack`=0, `alert_id`=0, `alert_on`=0, `busy`=0, `last_id`=NUM_REQ-1, all counters 0.
- Request to ack: a request seen in IDLE at cycle t sets `pend` at t+1. The ack pulse appears at t+2.
- Overlay start: `alert_on` rises the cycle after the first `ftick` following the grant. Visible display begins the following frame at the latest.
- Display length: exactly SHOW_FRAMES `ftick` intervals. The blink pattern is on for BLINK_FRAMES frames, then off for BLINK_FRAMES frames, and so on, starting on.
- Back-to-back alerts: the next grant happens in the cycle after GAP returns to IDLE.
- Reset mid-operation: within one cycle, everything returns to reset values. Pending requests are lost and `alert_on` drops immediately.
- Counters are sized `$clog2(max param)+1` bits and never wrap; they are loaded before use.

## Structure
- Shared package `alert_pkg`:
  - state enum `alert_state_t` {IDLE, ARM, SHOW, GAP};
  - localparams for the default frame counts;
  - `ALERT_ID_W` helper function.
- One sub-module, `rr_arbiter` (NUM_REQ). Combinational: takes `pend` and `last_id`, outputs `gnt_onehot` and `gnt_idx`, plus a `gnt_valid` flag.
- Top-level integration places `alert_sequencer` beside the alert mapper. `alert_on` selects the mapper's RGB in the color mux, and `alert_id` selects the image.

## Test plan
Parameters: SHOW_FRAMES=4, BLINK_FRAMES=2, GAP_FRAMES=1. The bench sweeps DrawX/DrawY over a shortened frame of 16×4 positions.

1. Reset, then a single pulse on `alert_req[2]`. Expected:
   - `alert_ack`=4'b0100 for exactly one cycle, `alert_id`=2;
   - `alert_on` high for frames 1–2, low for frames 3–4;
   - GAP for 1 frame, then `busy`=0.
2. `alert_req`=4'b1111 in one cycle. Expected grants in order 0,1,2,3, one per alert cycle, each separated by one gap frame; no request dropped.
3. `dismiss` in the second SHOW frame. Expected: SHOW ends at the next `ftick` and GAP follows. `dismiss` asserted in IDLE has no effect.
4. `alert_req[1]` asserted in the same cycle requester 1 is granted. Expected: `pend[1]` stays set and requester 1 is granted again after the gap.
5. Hold DrawX=0, DrawY=0 for 10 cycles. Expected: exactly one `ftick` and a single frame advance.
6. Assert `Reset` mid-SHOW. Expected: next cycle `alert_on`=0, `busy`=0, `pend`=0; a subsequent request grants requester 0 first.

Source files
------------

// File: rtl/alert_pkg.sv
// Shared types, default frame counts and width helpers for the alert overlay sequencer.
package alert_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        SHOW = 2'd2,
        GAP  = 2'd3
    } alert_state_t;

    localparam int DEF_NUM_REQ      = 4;
    localparam int DEF_SHOW_FRAMES  = 120;
    localparam int DEF_BLINK_FRAMES = 15;
    localparam int DEF_GAP_FRAMES   = 30;

    // Width of an alert index for n requesters (never below one bit).
    function automatic int ALERT_ID_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Frame counter width: enough bits for the largest frame count plus one.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches pending requests starting one past the last grant.
module rr_arbiter
    import alert_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]              pend_i,
    input  logic [ALERT_ID_W(NUM_REQ)-1:0]  last_id_i,
    output logic [NUM_REQ-1:0]              gnt_onehot_o,
    output logic [ALERT_ID_W(NUM_REQ)-1:0]  gnt_idx_o,
    output logic                            gnt_valid_o
);

    localparam int IDW = ALERT_ID_W(NUM_REQ);
    localparam logic [IDW:0] N_W = (IDW+1)'(NUM_REQ);

    logic [IDW:0] cand_s;

    // Walk the requesters in rotated order and take the first pending one.
    always_comb begin
        gnt_onehot_o = {NUM_REQ{1'b0}};
        gnt_idx_o    = {IDW{1'b0}};
        gnt_valid_o  = 1'b0;
        cand_s       = {(IDW+1){1'b0}};
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_s = {1'b0, last_id_i} + (IDW+1)'(k);
            if (cand_s >= N_W) begin
                cand_s = cand_s - N_W;
            end else begin
                cand_s = cand_s;
            end
            if (!gnt_valid_o && pend_i[cand_s[IDW-1:0]]) begin
                gnt_valid_o                     = 1'b1;
                gnt_idx_o                       = cand_s[IDW-1:0];
                gnt_onehot_o[cand_s[IDW-1:0]]   = 1'b1;
            end else begin
                gnt_valid_o = gnt_valid_o;
            end
        end
    end

endmodule

// File: rtl/alert_sequencer.sv
// Frame-synchronous alert overlay sequencer: queues requests, grants round-robin,
// shows each alert for a fixed number of frames with blinking, then enforces a gap.
module alert_sequencer
    import alert_pkg::*;
#(
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int SHOW_FRAMES  = DEF_SHOW_FRAMES,
    parameter int BLINK_FRAMES = DEF_BLINK_FRAMES,
    parameter int GAP_FRAMES   = DEF_GAP_FRAMES
) (
    input  logic                            vga_clk,
    input  logic                            Reset,
    input  logic [9:0]                      DrawX,
    input  logic [9:0]                      DrawY,
    input  logic [NUM_REQ-1:0]              alert_req,
    input  logic                            dismiss,
    output logic [NUM_REQ-1:0]              alert_ack,
    output logic [ALERT_ID_W(NUM_REQ)-1:0]  alert_id,
    output logic                            alert_on,
    output logic                            busy
);

    localparam int IDW   = ALERT_ID_W(NUM_REQ);
    localparam int CNT_W = cnt_width(SHOW_FRAMES, BLINK_FRAMES, GAP_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] SHOW_LOAD  = CNT_W'(SHOW_FRAMES - 1);
    localparam logic [CNT_W-1:0] BLINK_LOAD = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP_FRAMES > 0) ? GAP_FRAMES - 1 : 0);
    localparam logic             HAS_GAP    = (GAP_FRAMES > 0);
    localparam logic [IDW-1:0]   LAST_RST   = IDW'(NUM_REQ - 1);

    alert_state_t         state_q, state_d;
    logic [NUM_REQ-1:0]   pend_q, pend_d, clr_s;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [IDW-1:0]       alert_id_q, alert_id_d;
    logic [IDW-1:0]       last_id_q, last_id_d;
    logic [CNT_W-1:0]     frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]     blink_cnt_q, blink_cnt_d;
    logic [CNT_W-1:0]     gap_cnt_q, gap_cnt_d;
    logic                 phase_q, phase_d;
    logic                 dismiss_q, dismiss_d;
    logic                 alert_on_q, alert_on_d;
    logic                 busy_q, busy_d;
    logic                 origin_q;
    logic                 origin_s, ftick_s;
    logic [NUM_REQ-1:0]   gnt_onehot_s;
    logic [IDW-1:0]       gnt_idx_s;
    logic                 gnt_valid_s;

    // Frame tick: first cycle at the scan origin; holding the position cannot re-fire it.
    assign origin_s = (DrawX == 10'd0) && (DrawY == 10'd0);
    assign ftick_s  = origin_s && !origin_q;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .pend_i       (pend_q),
        .last_id_i    (last_id_q),
        .gnt_onehot_o (gnt_onehot_s),
        .gnt_idx_o    (gnt_idx_s),
        .gnt_valid_o  (gnt_valid_s)
    );

    // State register.
    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: grants leave IDLE, every other transition waits for a frame tick.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (gnt_valid_s) state_d = ARM;
                else             state_d = IDLE;
            end
            ARM: begin
                if (ftick_s) state_d = SHOW;
                else         state_d = ARM;
            end
            SHOW: begin
                if (ftick_s && ((frame_cnt_q == CNT_ZERO) || dismiss_q)) begin
                    state_d = HAS_GAP ? GAP : IDLE;
                end else begin
                    state_d = SHOW;
                end
            end
            GAP: begin
                if (ftick_s && (gap_cnt_q == CNT_ZERO)) state_d = IDLE;
                else                                    state_d = GAP;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values: pending queue, grant latch, frame/blink/gap counters.
    always_comb begin
        ack_d       = {NUM_REQ{1'b0}};
        clr_s       = {NUM_REQ{1'b0}};
        alert_id_d  = alert_id_q;
        last_id_d   = last_id_q;
        frame_cnt_d = frame_cnt_q;
        blink_cnt_d = blink_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        phase_d     = phase_q;

        if ((state_q == IDLE) && gnt_valid_s) begin
            ack_d      = gnt_onehot_s;
            clr_s      = gnt_onehot_s;
            alert_id_d = gnt_idx_s;
            last_id_d  = gnt_idx_s;
        end else begin
            ack_d      = {NUM_REQ{1'b0}};
        end

        // A new request in the grant cycle wins over the clear.
        pend_d = (pend_q & ~clr_s) | alert_req;

        case (state_q)
            ARM: begin
                if (ftick_s) begin
                    frame_cnt_d = SHOW_LOAD;
                    blink_cnt_d = BLINK_LOAD;
                    phase_d     = 1'b1;
                end else begin
                    phase_d     = phase_q;
                end
            end
            SHOW: begin
                if (ftick_s) begin
                    if (state_d == SHOW) begin
                        frame_cnt_d = frame_cnt_q - CNT_ONE;
                    end else begin
                        gap_cnt_d   = GAP_LOAD;
                    end
                    if (blink_cnt_q == CNT_ZERO) begin
                        blink_cnt_d = BLINK_LOAD;
                        phase_d     = ~phase_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q - CNT_ONE;
                    end
                end else begin
                    phase_d = phase_q;
                end
            end
            GAP: begin
                if (ftick_s && (gap_cnt_q != CNT_ZERO)) begin
                    gap_cnt_d = gap_cnt_q - CNT_ONE;
                end else begin
                    gap_cnt_d = gap_cnt_q;
                end
            end
            default: phase_d = phase_q;
        endcase

        // Dismiss is only remembered while an alert is being shown.
        if ((state_q == SHOW) && (state_d == SHOW)) begin
            dismiss_d = dismiss_q | dismiss;
        end else begin
            dismiss_d = 1'b0;
        end

        alert_on_d = (state_d == SHOW) && phase_d;
        busy_d     = (state_d != IDLE);
    end

    // Datapath and registered-output flops.
    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            pend_q      <= {NUM_REQ{1'b0}};
            ack_q       <= {NUM_REQ{1'b0}};
            alert_id_q  <= {IDW{1'b0}};
            last_id_q   <= LAST_RST;
            frame_cnt_q <= CNT_ZERO;
            blink_cnt_q <= CNT_ZERO;
            gap_cnt_q   <= CNT_ZERO;
            phase_q     <= 1'b0;
            dismiss_q   <= 1'b0;
            alert_on_q  <= 1'b0;
            busy_q      <= 1'b0;
            origin_q    <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            ack_q       <= ack_d;
            alert_id_q  <= alert_id_d;
            last_id_q   <= last_id_d;
            frame_cnt_q <= frame_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            phase_q     <= phase_d;
            dismiss_q   <= dismiss_d;
            alert_on_q  <= alert_on_d;
            busy_q      <= busy_d;
            origin_q    <= origin_s;
        end
    end

    assign alert_ack = ack_q;
    assign alert_id  = alert_id_q;
    assign alert_on  = alert_on_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_alert_sequencer.sv
// Directed self-checking bench for alert_sequencer on a shortened 16x4 frame.
module tb_alert_sequencer;

    logic       vga_clk   = 1'b0;
    logic       Reset     = 1'b1;
    logic [9:0] DrawX     = 10'd5;
    logic [9:0] DrawY     = 10'd0;
    logic [3:0] alert_req = 4'b0000;
    logic       dismiss   = 1'b0;
    logic       hold      = 1'b0;
    logic [3:0] alert_ack;
    logic [1:0] alert_id;
    logic       alert_on;
    logic       busy;

    int checks = 0;
    int errors = 0;

    alert_sequencer #(
        .NUM_REQ      (4),
        .SHOW_FRAMES  (4),
        .BLINK_FRAMES (2),
        .GAP_FRAMES   (1)
    ) dut (
        .vga_clk   (vga_clk),
        .Reset     (Reset),
        .DrawX     (DrawX),
        .DrawY     (DrawY),
        .alert_req (alert_req),
        .dismiss   (dismiss),
        .alert_ack (alert_ack),
        .alert_id  (alert_id),
        .alert_on  (alert_on),
        .busy      (busy)
    );

    always #5 vga_clk = ~vga_clk;

    // Scan position sweep over a 16x4 frame, or parked at the origin while hold is set.
    initial begin
        forever begin
            @(negedge vga_clk);
            if (hold) begin
                DrawX = 10'd0;
                DrawY = 10'd0;
            end else if (DrawX == 10'd15) begin
                DrawX = 10'd0;
                DrawY = (DrawY == 10'd3) ? 10'd0 : DrawY + 10'd1;
            end else begin
                DrawX = DrawX + 10'd1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    // Advance to just after the next frame-origin edge.
    task automatic next_frame();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!((DrawX == 10'd0) && (DrawY == 10'd0)) && (n < 200));
        check_eq("frame_found", {31'd0, (DrawX == 10'd0) && (DrawY == 10'd0)}, 32'd1);
    endtask

    // One full alert: ack pulse, on/on/off/off display, one gap frame, back to idle.
    task automatic expect_alert(input int id, input bit immediate, input string tag);
        int n;
        n = 0;
        if (immediate) begin
            tick();
        end else begin
            while ((alert_ack == 4'd0) && (n < 300)) begin
                tick();
                n++;
            end
        end
        check_eq({tag, "_ack"}, {28'd0, alert_ack}, 32'd1 << id);
        check_eq({tag, "_id"}, {30'd0, alert_id}, id);
        check_eq({tag, "_busy"}, {31'd0, busy}, 32'd1);
        tick();
        check_eq({tag, "_ack_pulse"}, {28'd0, alert_ack}, 32'd0);
        for (int f = 0; f < 4; f++) begin
            next_frame();
            check_eq($sformatf("%s_on_f%0d", tag, f + 1), {31'd0, alert_on}, (f < 2) ? 32'd1 : 32'd0);
            check_eq($sformatf("%s_id_f%0d", tag, f + 1), {30'd0, alert_id}, id);
            check_eq($sformatf("%s_busy_f%0d", tag, f + 1), {31'd0, busy}, 32'd1);
        end
        next_frame();
        check_eq({tag, "_gap_on"}, {31'd0, alert_on}, 32'd0);
        check_eq({tag, "_gap_busy"}, {31'd0, busy}, 32'd1);
        next_frame();
        check_eq({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        repeat (3) tick();
        Reset = 1'b0;
    endtask

    initial begin
        // Reset state.
        repeat (3) tick();
        check_eq("rst_ack", {28'd0, alert_ack}, 32'd0);
        check_eq("rst_id", {30'd0, alert_id}, 32'd0);
        check_eq("rst_on", {31'd0, alert_on}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        Reset = 1'b0;

        // 1: single pulse on requester 2, ack exactly two cycles after the request.
        next_frame();
        alert_req = 4'b0100;
        tick();
        alert_req = 4'b0000;
        check_eq("t1_ack_early", {28'd0, alert_ack}, 32'd0);
        expect_alert(2, 1'b1, "t1");

        // 2: all four at once after reset -> 0,1,2,3, each right after the previous gap.
        do_reset();
        next_frame();
        alert_req = 4'b1111;
        tick();
        alert_req = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            expect_alert(i, (i > 0), $sformatf("t2_%0d", i));
        end

        // 3: dismiss in the second shown frame ends the alert at the next tick.
        next_frame();
        alert_req = 4'b0010;
        tick();
        alert_req = 4'b0000;
        tick();
        check_eq("t3_ack", {28'd0, alert_ack}, 32'b0010);
        next_frame();
        check_eq("t3_on_f1", {31'd0, alert_on}, 32'd1);
        next_frame();
        check_eq("t3_on_f2", {31'd0, alert_on}, 32'd1);
        repeat (5) tick();
        dismiss = 1'b1;
        tick();
        dismiss = 1'b0;
        next_frame();
        check_eq("t3_gap_on", {31'd0, alert_on}, 32'd0);
        check_eq("t3_gap_busy", {31'd0, busy}, 32'd1);
        next_frame();
        check_eq("t3_idle_busy", {31'd0, busy}, 32'd0);
        // Dismiss while idle is ignored: the next alert runs its full length.
        dismiss = 1'b1;
        repeat (3) tick();
        dismiss = 1'b0;
        alert_req = 4'b0001;
        tick();
        alert_req = 4'b0000;
        expect_alert(0, 1'b1, "t3_idle_dismiss");

        // 4: request from 1 held through its own grant cycle stays pending.
        next_frame();
        alert_req = 4'b0010;
        tick();
        tick();
        alert_req = 4'b0000;
        expect_alert(1, 1'b0, "t4_first");
        expect_alert(1, 1'b1, "t4_regrant");

        // 5: origin held for 10 cycles gives a single frame advance.
        next_frame();
        alert_req = 4'b0100;
        tick();
        alert_req = 4'b0000;
        tick();
        check_eq("t5_ack", {28'd0, alert_ack}, 32'b0100);
        repeat (3) tick();
        hold = 1'b1;
        repeat (10) tick();
        check_eq("t5_hold_on", {31'd0, alert_on}, 32'd1);
        check_eq("t5_hold_busy", {31'd0, busy}, 32'd1);
        hold = 1'b0;
        next_frame();
        check_eq("t5_on_f2", {31'd0, alert_on}, 32'd1);
        next_frame();
        check_eq("t5_on_f3", {31'd0, alert_on}, 32'd0);
        next_frame();
        check_eq("t5_on_f4", {31'd0, alert_on}, 32'd0);
        check_eq("t5_busy_f4", {31'd0, busy}, 32'd1);
        next_frame();
        check_eq("t5_gap_busy", {31'd0, busy}, 32'd1);
        next_frame();
        check_eq("t5_idle_busy", {31'd0, busy}, 32'd0);

        // 6: reset in SHOW drops everything, including a queued request and the RR pointer.
        next_frame();
        alert_req = 4'b0100;
        tick();
        alert_req = 4'b0000;
        tick();
        check_eq("t6_ack", {28'd0, alert_ack}, 32'b0100);
        next_frame();
        check_eq("t6_on", {31'd0, alert_on}, 32'd1);
        repeat (4) tick();
        alert_req = 4'b1000;
        tick();
        alert_req = 4'b0000;
        repeat (3) tick();
        Reset = 1'b1;
        tick();
        check_eq("t6_rst_on", {31'd0, alert_on}, 32'd0);
        check_eq("t6_rst_busy", {31'd0, busy}, 32'd0);
        check_eq("t6_rst_id", {30'd0, alert_id}, 32'd0);
        check_eq("t6_rst_ack", {28'd0, alert_ack}, 32'd0);
        Reset = 1'b0;
        repeat (70) tick();
        check_eq("t6_pend_lost_busy", {31'd0, busy}, 32'd0);
        check_eq("t6_pend_lost_ack", {28'd0, alert_ack}, 32'd0);
        alert_req = 4'b1001;
        tick();
        alert_req = 4'b0000;
        tick();
        check_eq("t6_rr_ack", {28'd0, alert_ack}, 32'b0001);
        check_eq("t6_rr_id", {30'd0, alert_id}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
